// File: rtl/register_loader_pkg.sv
// Shared TD4 definitions: destination codes, default width and the write-back request.
// The source selector imports the same package so both ends agree on the codes.
package register_loader_pkg;

  localparam int TD4_W = 4;

  typedef enum logic [1:0] {
    DST_A   = 2'd0,
    DST_B   = 2'd1,
    DST_OUT = 2'd2,
    DST_PC  = 2'd3
  } dst_e;

  localparam int NUM_DST = 4;

  typedef struct packed {
    logic       ld_en;
    dst_e       ld;
  } wb_req_t;

endpackage

// File: rtl/register_loader_load_decoder.sv
// 2-to-4 one-hot load-enable decoder; all zeros when the enable is low.
module load_decoder
  import register_loader_pkg::*;
(
  input  logic [1:0]         ld,
  input  logic               ld_en,
  output logic [NUM_DST-1:0] en
);

  always_comb begin
    en = '0;
    if (ld_en) begin
      unique case (dst_e'(ld))
        DST_A:   en = 4'b0001;
        DST_B:   en = 4'b0010;
        DST_OUT: en = 4'b0100;
        DST_PC:  en = 4'b1000;
        default: en = '0;
      endcase
    end
  end

endmodule

// File: rtl/register_loader.sv
// TD4 write-back stage: steers ALU data into A/B/OUT/PC, runs the PC and carry flag.
// Every output is a flop; priority at each edge is RST > HOLD > normal update.
module register_loader
  import register_loader_pkg::*;
#(
  parameter int N = TD4_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N-1:0]       D,
  input  logic [1:0]         LD,
  input  logic               LD_EN,
  input  logic               CARRY_IN,
  input  logic               HOLD,
  output logic [N-1:0]       Q_A,
  output logic [N-1:0]       Q_B,
  output logic [N-1:0]       Q_OUT,
  output logic [N-1:0]       Q_PC,
  output logic               CARRY,
  output logic [NUM_DST-1:0] STROBE
);

  wb_req_t            req;
  logic [NUM_DST-1:0] en;
  logic [N-1:0]       pc_nxt;

  assign req = '{ld_en: LD_EN, ld: dst_e'(LD)};

  load_decoder u_dec (
    .ld    (req.ld),
    .ld_en (req.ld_en),
    .en    (en)
  );

  // A jump overrides the increment; the add wraps naturally at N bits.
  assign pc_nxt = en[DST_PC] ? D : Q_PC + N'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q_A    <= '0;
      Q_B    <= '0;
      Q_OUT  <= '0;
      Q_PC   <= '0;
      CARRY  <= 1'b0;
      STROBE <= '0;
    end else if (HOLD) begin
      STROBE <= '0;
    end else begin
      if (en[DST_A])   Q_A   <= D;
      if (en[DST_B])   Q_B   <= D;
      if (en[DST_OUT]) Q_OUT <= D;
      Q_PC   <= pc_nxt;
      CARRY  <= CARRY_IN;
      STROBE <= en;
    end
  end

endmodule

// File: tb/tb_register_loader.sv
// Directed bench for register_loader: table of per-edge vectors plus HOLD and mid-run reset sequences.
module tb_register_loader;

  logic       CLK = 1'b0;
  logic       RST, LD_EN, CARRY_IN, HOLD;
  logic [3:0] D;
  logic [1:0] LD;
  logic [3:0] Q_A, Q_B, Q_OUT, Q_PC, STROBE;
  logic       CARRY;

  int checks = 0;
  int errors = 0;

  register_loader #(.N(4)) dut (
    .CLK(CLK), .RST(RST), .D(D), .LD(LD), .LD_EN(LD_EN), .CARRY_IN(CARRY_IN),
    .HOLD(HOLD), .Q_A(Q_A), .Q_B(Q_B), .Q_OUT(Q_OUT), .Q_PC(Q_PC),
    .CARRY(CARRY), .STROBE(STROBE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, hold, ld_en, cin;
    logic [1:0] ld;
    logic [3:0] d;
    logic [3:0] a, b, o, pc, strobe;
    logic       c;
  } vec_t;

  vec_t tbl[11];

  // Apply inputs, clock one edge, compare the full register image 1 time unit later.
  task automatic step(input string name, input logic rst, input logic hold,
                      input logic ld_en, input logic [1:0] ld, input logic [3:0] d,
                      input logic cin, input logic [3:0] ea, input logic [3:0] eb,
                      input logic [3:0] eo, input logic [3:0] epc, input logic ec,
                      input logic [3:0] es);
    logic [20:0] got, exp;
    RST = rst; HOLD = hold; LD_EN = ld_en; LD = ld; D = d; CARRY_IN = cin;
    @(posedge CLK);
    #1;
    got = {Q_A, Q_B, Q_OUT, Q_PC, CARRY, STROBE};
    exp = {ea, eb, eo, epc, ec, es};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got A=%h B=%h OUT=%h PC=%h C=%b S=%b, required A=%h B=%h OUT=%h PC=%h C=%b S=%b",
               name, Q_A, Q_B, Q_OUT, Q_PC, CARRY, STROBE, ea, eb, eo, epc, ec, es);
    end
  endtask

  initial begin
    RST = 1'b1; HOLD = 1'b0; LD_EN = 1'b0; LD = 2'd0; D = 4'h0; CARRY_IN = 1'b0;

    //         rst hold en  cin ld  d      a     b     o     pc    strobe   c
    tbl[0]  = '{1, 0, 1, 1, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0};
    tbl[1]  = '{1, 0, 1, 1, 2'd3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0};
    tbl[2]  = '{0, 0, 1, 0, 2'd0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h1, 4'b0001, 0};
    tbl[3]  = '{0, 0, 1, 0, 2'd1, 4'hA, 4'h3, 4'hA, 4'h0, 4'h2, 4'b0010, 0};
    tbl[4]  = '{0, 0, 1, 0, 2'd2, 4'h5, 4'h3, 4'hA, 4'h5, 4'h3, 4'b0100, 0};
    tbl[5]  = '{0, 0, 1, 0, 2'd3, 4'hE, 4'h3, 4'hA, 4'h5, 4'hE, 4'b1000, 0};
    tbl[6]  = '{0, 0, 0, 0, 2'd3, 4'h7, 4'h3, 4'hA, 4'h5, 4'hF, 4'b0000, 0};
    tbl[7]  = '{0, 0, 0, 0, 2'd0, 4'h0, 4'h3, 4'hA, 4'h5, 4'h0, 4'b0000, 0};
    tbl[8]  = '{0, 0, 0, 1, 2'd0, 4'h0, 4'h3, 4'hA, 4'h5, 4'h1, 4'b0000, 1};
    tbl[9]  = '{0, 0, 0, 0, 2'd0, 4'h0, 4'h3, 4'hA, 4'h5, 4'h2, 4'b0000, 0};
    tbl[10] = '{0, 0, 0, 1, 2'd1, 4'h9, 4'h3, 4'hA, 4'h5, 4'h3, 4'b0000, 1};

    for (int i = 0; i < 11; i++)
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].hold, tbl[i].ld_en, tbl[i].ld,
           tbl[i].d, tbl[i].cin, tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].pc, tbl[i].c,
           tbl[i].strobe);

    // Bring PC to 5 with carry set, then stall with a pending load of A.
    step("pre_hold0", 0, 0, 0, 2'd0, 4'h0, 1, 4'h3, 4'hA, 4'h5, 4'h4, 1, 4'b0000);
    step("pre_hold1", 0, 0, 0, 2'd0, 4'h0, 1, 4'h3, 4'hA, 4'h5, 4'h5, 1, 4'b0000);
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), 0, 1, 1, 2'd0, 4'h9, 0,
           4'h3, 4'hA, 4'h5, 4'h5, 1, 4'b0000);
    step("hold_release", 0, 0, 0, 2'd0, 4'h9, 0, 4'h3, 4'hA, 4'h5, 4'h6, 0, 4'b0000);

    // Count to 9, then reset on the same edge as a jump to 7.
    step("cnt7", 0, 0, 0, 2'd0, 4'h0, 0, 4'h3, 4'hA, 4'h5, 4'h7, 0, 4'b0000);
    step("cnt8", 0, 0, 0, 2'd0, 4'h0, 0, 4'h3, 4'hA, 4'h5, 4'h8, 0, 4'b0000);
    step("cnt9", 0, 0, 0, 2'd0, 4'h0, 1, 4'h3, 4'hA, 4'h5, 4'h9, 1, 4'b0000);
    step("rst_vs_jump", 1, 0, 1, 2'd3, 4'h7, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000);
    step("post_rst_cnt", 0, 0, 0, 2'd0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 0, 4'b0000);
    step("post_rst_ldb", 0, 0, 1, 2'd1, 4'h4, 1, 4'h0, 4'h4, 4'h0, 4'h2, 1, 4'b0010);
    step("rst_vs_hold", 1, 1, 1, 2'd2, 4'hC, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
